// File: rtl/jtcus30_sndpost.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtcus30_sndpost: stereo post-processor for the CUS30 mix, with a           |
// | per-channel DC blocker, Q4.4 gain and 16-bit saturation.                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module jtcus30_sndpost #(
  parameter int DCW = 8,
  parameter int GSH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample,
  input  logic        [12:0] snd_l,
  input  logic        [12:0] snd_r,
  input  logic        [7:0]  gain,
  input  logic               dcrm_en,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid,
  output logic               busy,
  output logic               sat,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CH_L = 2'd1,
    S_CH_R = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [17:0] c_dc_max = 18'sd32767;
  localparam logic signed [17:0] c_dc_min = -18'sd32768;
  localparam logic signed [24:0] c_q_max  = 25'sd32767;
  localparam logic signed [24:0] c_q_min  = -25'sd32768;

  state_t             r_state, w_next;
  logic signed [12:0] r_x_l, r_x_r, r_xprev_l, r_xprev_r;
  logic signed [15:0] r_yprev_l, r_yprev_r, r_res_l, r_res_r;

  logic signed [12:0] w_x, w_xp;
  logic signed [15:0] w_yp, w_y, w_out;
  logic signed [17:0] w_dc;
  logic signed [24:0] w_p, w_q;
  logic               w_dc_clamp, w_q_clamp, w_sat;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (sample) w_next = S_CH_L;
      S_CH_L:  w_next = S_CH_R;
      S_CH_R:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // One datapath shared by both channels; channel chosen by the FSM state.
  assign w_x  = (r_state == S_CH_R) ? r_x_r     : r_x_l;
  assign w_xp = (r_state == S_CH_R) ? r_xprev_r : r_xprev_l;
  assign w_yp = (r_state == S_CH_R) ? r_yprev_r : r_yprev_l;

  assign w_dc = $signed({{5{w_x[12]}}, w_x}) - $signed({{5{w_xp[12]}}, w_xp})
              + $signed({{2{w_yp[15]}}, w_yp})
              - $signed({{2{w_yp[15]}}, 16'(w_yp >>> DCW)});

  assign w_dc_clamp = dcrm_en && ((w_dc > c_dc_max) || (w_dc < c_dc_min));

  always_comb begin
    w_y = {{3{w_x[12]}}, w_x};
    if (dcrm_en) begin
      if (w_dc > c_dc_max)      w_y = 16'sh7FFF;
      else if (w_dc < c_dc_min) w_y = -16'sh8000;
      else                      w_y = w_dc[15:0];
    end
  end

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign w_p = $signed({{9{w_y[15]}}, w_y}) * $signed({17'd0, gain});
  assign w_q = w_p >>> GSH;
  assign w_q_clamp = (w_q > c_q_max) || (w_q < c_q_min);

  always_comb begin
    w_out = w_q[15:0];
    if (w_q > c_q_max)      w_out = 16'sh7FFF;
    else if (w_q < c_q_min) w_out = -16'sh8000;
  end

  assign w_sat = w_dc_clamp || w_q_clamp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_x_l     <= '0;
      r_x_r     <= '0;
      r_xprev_l <= '0;
      r_xprev_r <= '0;
      r_yprev_l <= '0;
      r_yprev_r <= '0;
      r_res_l   <= '0;
      r_res_r   <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_state   <= w_next;
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sample) begin
            r_x_l <= snd_l;
            r_x_r <= snd_r;
          end
        end
        S_CH_L: begin
          r_xprev_l <= w_x;
          r_yprev_l <= dcrm_en ? w_y : 16'sd0;
          r_res_l   <= w_out;
          if (w_sat) sat <= 1'b1;
        end
        S_CH_R: begin
          r_xprev_r <= w_x;
          r_yprev_r <= dcrm_en ? w_y : 16'sd0;
          r_res_r   <= w_out;
          if (w_sat) sat <= 1'b1;
        end
        default: begin
          out_l     <= r_res_l;
          out_r     <= r_res_r;
          out_valid <= 1'b1;
        end
      endcase
      if (sample && (r_state != S_IDLE)) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtcus30_sndpost.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jtcus30_sndpost: randomized self-checking bench for jtcus30_sndpost.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_jtcus30_sndpost;

  localparam int DCW = 8;
  localparam int GSH = 4;

  logic               clk = 1'b0;
  logic               rst_n, sample, dcrm_en;
  logic        [12:0] snd_l, snd_r;
  logic        [7:0]  gain;
  logic signed [15:0] out_l, out_r;
  logic               out_valid, busy, sat, overrun;

  int total = 0;
  int bad   = 0;

  // Reference state: previous input/output per channel and sticky flags.
  int xp[2];
  int yp[2];
  bit e_sat, e_ovr;
  int prev_l, prev_r;

  always #5 clk = ~clk;

  jtcus30_sndpost #(.DCW(DCW), .GSH(GSH)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .snd_l(snd_l), .snd_r(snd_r),
    .gain(gain), .dcrm_en(dcrm_en), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .busy(busy), .sat(sat), .overrun(overrun)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) begin e_sat = 1'b1; return 32767; end
    if (v < -32768) begin e_sat = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic int model_ch(input int ch, input int x, input bit en, input int g);
    int y;
    if (en) begin
      y = clamp16(x - xp[ch] + yp[ch] - (yp[ch] >>> DCW));
      yp[ch] = y;
    end else begin
      y = x;
      yp[ch] = 0;
    end
    xp[ch] = x;
    return clamp16((y * g) >>> GSH);
  endfunction

  function automatic void model_reset();
    xp[0] = 0; xp[1] = 0; yp[0] = 0; yp[1] = 0;
    e_sat = 1'b0; e_ovr = 1'b0;
    prev_l = 0; prev_r = 0;
  endfunction

  function automatic int rnd13();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // One sample through the pipeline; returns at the cycle after E3 (out_valid high).
  task automatic run_txn(input int l, input int r, input bit en_l, input int g_l,
                         input bit en_r, input int g_r, input bit ovr, input bit rst_mid);
    int exp_l, exp_r;
    snd_l = 13'(l); snd_r = 13'(r);
    dcrm_en = en_l; gain = 8'(g_l);
    sample = 1'b1;
    tick();                                   // E0 -> CH_L
    chk("busy_chl", busy, 1);
    chk("ovalid_chl", out_valid, 0);
    if (ovr) begin
      sample = 1'b1;
      snd_l = 13'(rnd13()); snd_r = 13'(rnd13());
      e_ovr = 1'b1;
    end else begin
      sample = 1'b0;
    end
    exp_l = model_ch(0, l, en_l, g_l);
    tick();                                   // E1 -> CH_R
    sample = 1'b0;
    dcrm_en = en_r; gain = 8'(g_r);
    if (rst_mid) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      model_reset();
      chk("rst_mid_ovalid", out_valid, 0);
      chk("rst_mid_out_l", int'(out_l), 0);
      chk("rst_mid_out_r", int'(out_r), 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ovr", overrun, 0);
      tick();
      chk("rst_mid_ovalid2", out_valid, 0);
      tick();
      chk("rst_mid_ovalid3", out_valid, 0);
      return;
    end
    exp_r = model_ch(1, r, en_r, g_r);
    tick();                                   // E2 -> DONE
    dcrm_en = 1'($urandom); gain = 8'($urandom);
    chk("hold_l", int'(out_l), prev_l);
    chk("hold_r", int'(out_r), prev_r);
    chk("ovalid_done", out_valid, 0);
    chk("busy_done", busy, 1);
    tick();                                   // E3 -> IDLE, outputs update
    chk("ovalid", out_valid, 1);
    chk("busy_idle", busy, 0);
    chk("out_l", int'(out_l), exp_l);
    chk("out_r", int'(out_r), exp_r);
    chk("sat", sat, int'(e_sat));
    chk("overrun", overrun, int'(e_ovr));
    prev_l = exp_l; prev_r = exp_r;
  endtask

  initial begin
    rst_n = 1'b0; sample = 1'b1; dcrm_en = 1'b0; gain = 8'h10;
    snd_l = 13'd123; snd_r = 13'd456;
    model_reset();
    tick();
    tick();
    chk("rst_out_l", int'(out_l), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1; sample = 1'b0;
    tick();

    // DC blocker from zero state: 1000, 997, 994
    run_txn(1000, 1000, 1, 16, 1, 16, 0, 0);
    chk("dc_first", int'(out_l), 1000);
    run_txn(1000, 1000, 1, 16, 1, 16, 0, 0);
    chk("dc_second", int'(out_l), 997);
    run_txn(1000, 1000, 1, 16, 1, 16, 0, 0);
    chk("dc_third", int'(out_l), 994);

    // Bypass, unity gain
    run_txn(100, -50, 0, 16, 0, 16, 0, 0);
    chk("byp_l", int'(out_l), 100);
    chk("byp_r", int'(out_r), -50);
    tick();
    chk("byp_pulse_end", out_valid, 0);

    // Saturation in the gain stage
    run_txn(4095, -4096, 0, 255, 0, 255, 0, 0);
    chk("sat_l", int'(out_l), 32767);
    chk("sat_r", int'(out_r), -32768);
    chk("sat_flag", sat, 1);

    // Overrun, then a sample accepted right in the out_valid cycle
    run_txn(200, -300, 0, 16, 0, 16, 1, 0);
    chk("ovr_l", int'(out_l), 200);
    chk("ovr_flag", overrun, 1);
    run_txn(-7, 9, 0, 32, 0, 8, 0, 0);
    chk("b2b_l", int'(out_l), -14);
    chk("b2b_r", int'(out_r), 4);

    // Reset mid-operation, then fresh DC result from zero state
    run_txn(500, 600, 1, 16, 1, 16, 0, 1);
    run_txn(1000, -1000, 1, 16, 1, 16, 0, 0);
    chk("post_rst_l", int'(out_l), 1000);
    chk("post_rst_r", int'(out_r), -1000);

    for (int i = 0; i < 60; i++) begin
      int idle;
      run_txn(rnd13(), rnd13(), 1'($urandom), int'($urandom_range(0, 255)),
              1'($urandom), int'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
      idle = int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
